// File: rtl/f_pcgen_btb_pkg.sv
// f_pcgen_btb_pkg: shared widths, BTB entry layout, reset PC and FSM encodings
package f_pcgen_btb_pkg;
    localparam int PC_W  = 13;
    localparam int IDX_W = 11;
    localparam int TAG_W = 2;
    localparam int ENT_W = 16;
    localparam int VALID_BIT = 15;
    localparam int TAG_HI = 14;
    localparam int TAG_LO = 13;
    localparam int TGT_HI = 12;
    localparam logic [PC_W-1:0] RESET_PC = 13'h0000;
    localparam logic [IDX_W-1:0] LAST_IDX = 11'h7FF;
    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;
    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [PC_W-1:0]  target;
    } btb_entry_t;
endpackage

// File: rtl/f_pcgen_btb_btb_mem.sv
// btb_mem: 2048x16 BTB storage, async read, sync write, no reset
// ports: clk; we_i/waddr_i/wdata_i write port; raddr_i/rdata_o read port
module f_pcgen_btb_btb_mem
    import f_pcgen_btb_pkg::*;
(
    input  logic             clk,
    input  logic             we_i,
    input  logic [IDX_W-1:0] waddr_i,
    input  logic [ENT_W-1:0] wdata_i,
    input  logic [IDX_W-1:0] raddr_i,
    output logic [ENT_W-1:0] rdata_o
);
    logic [ENT_W-1:0] mem [0:(1<<IDX_W)-1];
    always_ff @(posedge clk) begin
        if (we_i) mem[waddr_i] <= wdata_i;
    end
    assign rdata_o = mem[raddr_i];
endmodule

// File: rtl/f_pcgen_btb.sv
// f_pcgen_btb: fetch PC generator with direct-mapped BTB prediction
// ports: clk, rst (sync, active-high); stall, redirect/redirect_pc from execute;
//        bp_wen/bp_waddr/bp_wdata BTB update; pc_out, pc_predicted_out, valid_out, init_busy
module f_pcgen_btb
    import f_pcgen_btb_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             redirect,
    input  logic [PC_W-1:0]  redirect_pc,
    input  logic             bp_wen,
    input  logic [IDX_W-1:0] bp_waddr,
    input  logic [ENT_W-1:0] bp_wdata,
    output logic [PC_W-1:0]  pc_out,
    output logic [PC_W-1:0]  pc_predicted_out,
    output logic             valid_out,
    output logic             init_busy
);
    logic [0:0]       state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic             init;
    logic             mem_we;
    logic [IDX_W-1:0] mem_waddr;
    logic [ENT_W-1:0] mem_wdata;
    logic [ENT_W-1:0] mem_rdata;
    btb_entry_t       ent;
    logic             hit;
    assign init = state_q == ST_INIT;
    // the clear sweep owns the write port until every entry has been zeroed
    assign mem_we    = init | bp_wen;
    assign mem_waddr = init ? cnt_q : bp_waddr;
    assign mem_wdata = init ? '0 : bp_wdata;
    f_pcgen_btb_btb_mem u_btb (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (mem_waddr),
        .wdata_i (mem_wdata),
        .raddr_i (pc_q[IDX_W-1:0]),
        .rdata_o (mem_rdata)
    );
    assign ent = btb_entry_t'(mem_rdata);
    assign hit = ent.valid & (ent.tag == pc_q[PC_W-1:IDX_W]);
    always_comb begin
        pc_predicted_out = init ? RESET_PC + 13'd1 : hit ? ent.target : pc_q + 13'd1;
        pc_d    = init ? RESET_PC : redirect ? redirect_pc : stall ? pc_q : pc_predicted_out;
        cnt_d   = init ? cnt_q + 11'd1 : cnt_q;
        state_d = (init && cnt_q == LAST_IDX) ? ST_RUN : state_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
        end
    end
    assign pc_out    = pc_q;
    assign valid_out = ~init;
    assign init_busy = init;
endmodule

// File: tb/tb_f_pcgen_btb.sv
// tb_f_pcgen_btb: directed plus randomized checks against a behavioural PC/BTB model
module tb_f_pcgen_btb;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [12:0] redirect_pc = '0;
    logic        bp_wen = 1'b0;
    logic [10:0] bp_waddr = '0;
    logic [15:0] bp_wdata = '0;
    logic [12:0] pc_out;
    logic [12:0] pc_predicted_out;
    logic        valid_out;
    logic        init_busy;

    f_pcgen_btb dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .redirect         (redirect),
        .redirect_pc      (redirect_pc),
        .bp_wen           (bp_wen),
        .bp_waddr         (bp_waddr),
        .bp_wdata         (bp_wdata),
        .pc_out           (pc_out),
        .pc_predicted_out (pc_predicted_out),
        .valid_out        (valid_out),
        .init_busy        (init_busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model: table of entries, current PC, cycles of clearing still to go
    logic [15:0] m_btb [0:2047];
    int          m_left;
    logic [12:0] m_pc;
    bit          known = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [12:0] m_pred();
        logic [15:0] e;
        if (m_left > 0) return 13'd1;
        e = m_btb[m_pc % 2048];
        if (e[15] && e[14:13] == m_pc / 2048) return e[12:0];
        return 13'((m_pc + 1) % 8192);
    endfunction

    // one clock: drive at negedge, check before the edge, advance model at the edge
    task automatic cyc(input logic r, input logic st, input logic rd, input logic [12:0] rpc,
                       input logic we, input logic [10:0] wa, input logic [15:0] wd);
        logic [12:0] p;
        rst = r; stall = st; redirect = rd; redirect_pc = rpc;
        bp_wen = we; bp_waddr = wa; bp_wdata = wd;
        #1;
        if (known) begin
            p = m_pred();
            chk("pc_out", {3'b0, pc_out}, {3'b0, m_pc});
            chk("valid_out", {15'b0, valid_out}, {15'b0, m_left == 0});
            chk("init_busy", {15'b0, init_busy}, {15'b0, m_left != 0});
            if (m_left == 0) chk("pred", {3'b0, pc_predicted_out}, {3'b0, p});
        end
        @(posedge clk);
        if (r) begin
            known = 1;
            m_left = 2048;
            m_pc = 13'h0000;
            for (int i = 0; i < 2048; i++) m_btb[i] = '0;
        end else if (known && m_left > 0) begin
            m_left--;
        end else if (known) begin
            p = m_pred();
            if (we) m_btb[wa] = wd;
            m_pc = rd ? rpc : st ? m_pc : p;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, '0, 0, '0, '0);
    endtask

    task automatic do_reset();
        cyc(1, 0, 0, '0, 0, '0, '0);
        // inputs that must be ignored while clearing
        for (int i = 0; i < 2048; i++)
            cyc(0, i[0], i[1], 13'h0AAA, i[2], 11'(i), 16'hFFFF);
    endtask

    initial begin
        @(negedge clk);
        do_reset();
        chk("run_valid", {15'b0, valid_out}, 16'd1);
        chk("run_pc0", {3'b0, pc_out}, 16'h0000);
        idle(2);
        chk("seq_pc2", {3'b0, pc_out}, 16'h0002);
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, '0, 0, '0, '0);
        chk("stall_hold", {3'b0, pc_out}, 16'h0002);
        cyc(0, 0, 1, 13'h1FFF, 0, '0, '0);
        idle(1);
        chk("wrap", {3'b0, pc_out}, 16'h0000);
        cyc(0, 0, 0, '0, 1, 11'd5, {1'b1, 2'b00, 13'h0040});
        cyc(0, 0, 1, 13'h0005, 0, '0, '0);
        chk("hit_pred", {3'b0, pc_predicted_out}, 16'h0040);
        idle(1);
        chk("hit_pc", {3'b0, pc_out}, 16'h0040);
        cyc(0, 0, 1, 13'h0805, 0, '0, '0);
        chk("tagmiss_pred", {3'b0, pc_predicted_out}, 16'h0806);
        idle(1);
        chk("tagmiss_pc", {3'b0, pc_out}, 16'h0806);
        cyc(0, 1, 1, 13'h0123, 0, '0, '0);
        chk("redir_over_stall", {3'b0, pc_out}, 16'h0123);
        cyc(0, 0, 1, 13'h0007, 0, '0, '0);
        cyc(0, 1, 0, '0, 1, 11'd7, {1'b1, 2'b00, 13'h0200});
        chk("old_entry", {3'b0, pc_out}, 16'h0007);
        cyc(0, 1, 0, '0, 0, '0, '0);
        idle(1);
        chk("new_entry", {3'b0, pc_out}, 16'h0200);
        for (int i = 0; i < 600; i++) begin
            logic [12:0] rp;
            logic [10:0] wa;
            logic [15:0] wd;
            rp = 13'($urandom_range(0, 15)) | (13'($urandom_range(0, 3)) << 11);
            wa = ($urandom_range(0, 1) == 1) ? pc_out[10:0] : 11'($urandom_range(0, 15));
            wd = {1'($urandom), ($urandom_range(0, 1) == 1) ? pc_out[12:11] : 2'($urandom),
                  13'($urandom_range(0, 15)) | (13'($urandom_range(0, 3)) << 11)};
            cyc(0, $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, rp,
                $urandom_range(0, 2) == 0, wa, wd);
        end
        cyc(0, 0, 0, '0, 1, 11'd5, {1'b1, 2'b00, 13'h0040});
        do_reset();
        cyc(0, 0, 1, 13'h0005, 0, '0, '0);
        chk("cleared_pred", {3'b0, pc_predicted_out}, 16'h0006);
        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
